gpa_fhdo_iface: RTL and testbench

GPA_FHDO_IFACE -- requirements
Module: gpa_fhdo_iface

---
 rtl/gpa_fhdo_iface.sv | 113 +++++++++++
 tb/tb_gpa_fhdo_iface.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gpa_fhdo_iface.sv
// gpa_fhdo_iface: sends four latched 24-bit words as separate SPI frames to a DAC80504, MSB first.
module gpa_fhdo_iface #(
  parameter int CSN_GAP = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] datax_i,
  input  logic [23:0] datay_i,
  input  logic [23:0] dataz_i,
  input  logic [23:0] dataz2_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        fhd_clk_o,
  output logic        fhd_sdo_o,
  output logic        fhd_csn_o,
  input  logic        fhd_sdi_i
);
  localparam int GW = CSN_GAP > 1 ? $clog2(CSN_GAP) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t           state_q, state_d;
  logic [4:0]       bit_q, bit_d;
  logic             phase_q, phase_d;
  logic [1:0]       frame_q, frame_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [3:0][23:0] word_q, word_d;
  logic             busy_q, busy_d, csn_q, csn_d, sclk_q, sclk_d, sdo_q, sdo_d;
  logic             sdi_unused;
  assign sdi_unused = fhd_sdi_i;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    word_d  = word_q;
    busy_d  = busy_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    case (state_q)
      IDLE: if (valid_i) begin
        word_d  = {dataz2_i, dataz_i, datay_i, datax_i};
        state_d = SHIFT;
        bit_d   = 5'd23;
        phase_d = 1'b0;
        frame_d = 2'd0;
        busy_d  = 1'b1;
        csn_d   = 1'b0;
        sclk_d  = 1'b1;
        sdo_d   = datax_i[23];
      end
      SHIFT: if (!phase_q) begin
        phase_d = 1'b1;
        sclk_d  = 1'b0;
      end else if (bit_q != 5'd0) begin
        bit_d   = bit_q - 5'd1;
        phase_d = 1'b0;
        sclk_d  = 1'b1;
        sdo_d   = word_q[frame_q][bit_q - 5'd1];
      end else begin
        state_d = GAP;
        gap_d   = '0;
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
        sdo_d   = 1'b0;
      end
      GAP: if (gap_q != GW'(CSN_GAP - 1)) begin
        gap_d = gap_q + 1'b1;
      end else if (frame_q == 2'd3) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = SHIFT;
        frame_d = frame_q + 2'd1;
        bit_d   = 5'd23;
        phase_d = 1'b0;
        csn_d   = 1'b0;
        sclk_d  = 1'b1;
        sdo_d   = word_q[frame_q + 2'd1][23];
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bit_q   <= '0;
      phase_q <= 1'b0;
      frame_q <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
    end
  end
  assign busy_o    = busy_q;
  assign fhd_csn_o = csn_q;
  assign fhd_clk_o = sclk_q;
  assign fhd_sdo_o = sdo_q;
endmodule

// File: tb/tb_gpa_fhdo_iface.sv
// tb_gpa_fhdo_iface: scoreboard bench with a DAC-side SPI monitor checking frames, gaps and busy length.
module tb_gpa_fhdo_iface;
  logic        clk = 0, resetn = 0, valid = 0, sdi = 0;
  logic [23:0] dx = 0, dy = 0, dz = 0, dz2 = 0;
  logic        busy, sclk, sdo, csn;
  int          n_cmp = 0, n_bad = 0;
  logic [23:0] exp_q[$];
  logic [15:0] vout[4];
  logic [3:0]  tr[210], tr0[210];
  gpa_fhdo_iface #(.CSN_GAP(2)) dut (
    .clk(clk), .resetn(resetn), .datax_i(dx), .datay_i(dy), .dataz_i(dz), .dataz2_i(dz2),
    .valid_i(valid), .busy_o(busy), .fhd_clk_o(sclk), .fhd_sdo_o(sdo), .fhd_csn_o(csn),
    .fhd_sdi_i(sdi)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // Caller must be just after a negedge so the request lands on the next rising edge.
  task automatic send(input logic [23:0] x, y, z, w, input bit acc);
    dx = x; dy = y; dz = z; dz2 = w; valid = 1;
    @(posedge clk); #1;
    chk("start_busy", busy, 1);
    if (acc) begin
      exp_q.push_back(x); exp_q.push_back(y); exp_q.push_back(z); exp_q.push_back(w);
      chk("start_csn", csn, 0);
      chk("start_sclk", sclk, 1);
      chk("start_sdo", sdo, x[23]);
    end
    valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask
  task automatic trace(input bit rnd);
    @(negedge clk);
    send(24'h123456, 24'h00ABCD, 24'h800001, 24'h7FFFFE, 1);
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      tr[i] = {busy, csn, sclk, sdo};
      sdi = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    sdi = 0;
  endtask
  // DAC-side monitor: samples SDO on falling SCLK while CSN is low.
  initial begin
    logic [23:0] sr = 0, e;
    int nbits = 0, gapcnt = 0, busycnt = 0;
    bit in_gap = 0;
    logic pcsn = 1, psclk = 0, pbusy = 0;
    logic [1:0] ch = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        sr = 0; nbits = 0; gapcnt = 0; busycnt = 0; in_gap = 0;
      end else begin
        if (busy && !pbusy) ch = 0;
        if (in_gap) begin
          if (csn && busy) gapcnt++;
          else begin
            chk("csn_gap", gapcnt, 2);
            in_gap = 0;
          end
        end
        if (!csn && psclk && !sclk) begin
          sr = {sr[22:0], sdo};
          nbits++;
        end
        if (csn && !pcsn) begin
          chk("frame_bits", nbits, 24);
          if (exp_q.size() == 0) chk("unexpected_frame", sr, 24'hxxxxxx);
          else begin
            e = exp_q.pop_front();
            chk("frame_word", sr, e);
          end
          vout[ch] = sr[15:0];
          ch++;
          nbits = 0;
          in_gap = 1;
          gapcnt = 1;
        end
        if (busy) busycnt++;
        else if (busycnt > 0) begin
          chk("busy_len", busycnt, 200);
          busycnt = 0;
        end
      end
      pcsn = csn; psclk = sclk; pbusy = busy;
    end
  end
  initial begin
    #12;
    chk("rst_csn", csn, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); resetn = 1;
    @(negedge clk);
    send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("vout_a", 32'(vout[i]), 32'(i + 1));
    send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1);
    wait_idle();
    send(24'h000005, 24'h000006, 24'h000007, 24'h000008, 1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("vout_b", 32'(vout[i]), 32'(i + 5));
    @(negedge clk);
    send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1);
    repeat (49) @(negedge clk);
    send(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0);
    wait_idle();
    @(negedge clk);
    send(24'hA5A5A5, 24'h5A5A5A, 24'hC00003, 24'h000000, 1);
    wait_idle();
    @(negedge clk);
    send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1);
    repeat (76) @(posedge clk);
    #3 resetn = 0;
    #1;
    chk("arst_csn", csn, 1);
    chk("arst_busy", busy, 0);
    chk("arst_sclk", sclk, 0);
    chk("arst_sdo", sdo, 0);
    repeat (3) @(negedge clk);
    resetn = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy, csn}, 2'b01);
    send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1);
    wait_idle();
    trace(0);
    tr0 = tr;
    trace(1);
    begin
      int d = 0;
      for (int i = 0; i < 210; i++) if (tr[i] !== tr0[i]) d++;
      chk("sdi_independent", d, 0);
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
